// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and LSU writeback requests onto one
// registered register-file write port and tracks pending writes in a
// 32-entry busy scoreboard with combinational hazard detection.
// Define WB_RR_ARB_EN for round-robin tie-breaking; by default the LSU
// always wins a tie.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [WIDTH-1:0] lsu_data,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       chk_rs1,
    input  logic [4:0]       chk_rs2,
    output logic             hazard,
    output logic [31:0]      busy,
    output logic             wb_we,
    output logic [4:0]       wb_reg,
    output logic [WIDTH-1:0] wb_data
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } grant_e;

    grant_e           w_grant;
    logic             w_alu_wins_tie;
    logic [4:0]       w_sel_rd;
    logic [WIDTH-1:0] w_sel_data;
    logic [31:0]      w_set_mask;
    logic [31:0]      w_clr_mask;

    logic             r_wb_we;
    logic [4:0]       r_wb_reg;
    logic [WIDTH-1:0] r_wb_data;
    logic [31:0]      r_busy;

`ifdef WB_RR_ARB_EN
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_LSU = 1'b1
    } last_e;

    last_e r_last;

    // Remember which requester was granted last so a tie goes to the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= LAST_LSU;
        end else if (w_grant == GNT_ALU) begin
            r_last <= LAST_ALU;
        end else if (w_grant == GNT_LSU) begin
            r_last <= LAST_LSU;
        end
    end

    assign w_alu_wins_tie = (r_last == LAST_LSU);
`else
    assign w_alu_wins_tie = 1'b0;
`endif

    // Pick at most one requester; nothing is granted while reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_grant    = GNT_NONE;
        w_sel_rd   = 5'd0;
        w_sel_data = '0;
        if (!rst) begin
            if (alu_valid && (!lsu_valid || w_alu_wins_tie)) begin
                w_grant = GNT_ALU;
            end else if (lsu_valid) begin
                w_grant = GNT_LSU;
            end
        end
        if (w_grant == GNT_ALU) begin
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end else if (w_grant == GNT_LSU) begin
            w_sel_rd   = lsu_rd;
            w_sel_data = lsu_data;
        end
    end

    assign alu_ready = (w_grant == GNT_ALU);
    assign lsu_ready = (w_grant == GNT_LSU);

    // Register the granted write; a grant to x0 is consumed but never written.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            r_wb_we   <= 1'b0;
            r_wb_reg  <= 5'd0;
            r_wb_data <= '0;
        end else begin
            r_wb_we <= 1'b0;
            if (w_grant != GNT_NONE && w_sel_rd != 5'd0) begin
                r_wb_we   <= 1'b1;
                r_wb_reg  <= w_sel_rd;
                r_wb_data <= w_sel_data;
            end
        end
    end

    // Issue sets a bit, the committing write clears it; set wins on collision.
    always_comb begin
        w_set_mask = 32'd0;
        w_clr_mask = 32'd0;
        if (issue_valid && issue_rd != 5'd0) begin
            w_set_mask = 32'd1 << issue_rd;
        end
        if (r_wb_we) begin
            w_clr_mask = 32'd1 << r_wb_reg;
        end
    end

    // Busy scoreboard; bit 0 is forced low because x0 is never pending.
    always_ff @(posedge clk) begin
        // NOTE: the scoreboard is only 32 flops, so it is cleared by reset like any other state.
        if (rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
        end
    end

    assign hazard  = ((chk_rs1 != 5'd0) && r_busy[chk_rs1]) ||
                     ((chk_rs2 != 5'd0) && r_busy[chk_rs2]);
    assign busy    = r_busy;
    assign wb_we   = r_wb_we;
    assign wb_reg  = r_wb_reg;
    assign wb_data = r_wb_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus; expected writebacks are queued
// when a request is issued and a negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic             clk;
    logic             rst;
    logic             alu_valid;
    logic             alu_ready;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             lsu_valid;
    logic             lsu_ready;
    logic [4:0]       lsu_rd;
    logic [WIDTH-1:0] lsu_data;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [4:0]       chk_rs1;
    logic [4:0]       chk_rs2;
    logic             hazard;
    logic [31:0]      busy;
    logic             wb_we;
    logic [4:0]       wb_reg;
    logic [WIDTH-1:0] wb_data;

    int  n_tests = 0;
    int  n_fail  = 0;
    wb_t exp_q[$];
    wb_t mon_e;

    regfile_wb_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .hazard      (hazard),
        .busy        (busy),
        .wb_we       (wb_we),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wb_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got reg %0d data 0x%08h expected no write at %0t",
                         wb_reg, wb_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_reg", {27'd0, wb_reg}, {27'd0, mon_e.rd});
                check("wb_data", wb_data, mon_e.data);
            end
        end
    end

    initial begin
        logic   exp_lsu;
        int     a_cnt;
        int     l_cnt;

        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0;

        // Reset state
        step();
        step();
        mid();
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_wb_we", {31'd0, wb_we}, 32'd0);
        check("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);

        // Single ALU write, latency 1, one-cycle strobe, then hold
        step();
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        mid();
        check("single_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("single_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        push(5'd5, 32'hDEADBEEF);
        step();
        alu_valid = 1'b0;
        mid();
        check("single_wb_we", {31'd0, wb_we}, 32'd1);
        step();
        mid();
        check("single_wb_we_drop", {31'd0, wb_we}, 32'd0);
        check("hold_wb_reg", {27'd0, wb_reg}, 32'd5);
        check("hold_wb_data", wb_data, 32'hDEADBEEF);

        // Contention after a fresh reset
        step();
        rst = 1'b1;
        mid();
        step();
        rst = 1'b0;
        a_cnt = 0;
        l_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000_0000 + 32'(a_cnt);
            lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB000_0000 + 32'(l_cnt);
            mid();
`ifdef WB_RR_ARB_EN
            exp_lsu = (i % 2 == 1);
`else
            exp_lsu = 1'b1;
`endif
            check("tie_alu_ready", {31'd0, alu_ready}, {31'd0, !exp_lsu});
            check("tie_lsu_ready", {31'd0, lsu_ready}, {31'd0, exp_lsu});
            if (exp_lsu) begin
                push(5'd2, 32'hB000_0000 + 32'(l_cnt));
                l_cnt++;
            end else begin
                push(5'd1, 32'hA000_0000 + 32'(a_cnt));
                a_cnt++;
            end
            step();
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        mid();

        // Hazard tracking through an LSU write
        step();
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        chk_rs1 = 5'd7;
        mid();
        check("issue7_busy", busy, 32'h0000_0080);
        check("issue7_hazard_rs1", {31'd0, hazard}, 32'd1);
        chk_rs1 = 5'd0; chk_rs2 = 5'd7;
        #1;
        check("issue7_hazard_rs2", {31'd0, hazard}, 32'd1);
        chk_rs2 = 5'd8;
        #1;
        check("rs2_8_no_hazard", {31'd0, hazard}, 32'd0);
        step();
        chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777_7777;
        mid();
        check("lsu7_ready", {31'd0, lsu_ready}, 32'd1);
        push(5'd7, 32'h7777_7777);
        step();
        lsu_valid = 1'b0;
        mid();
        check("lsu7_wb_we", {31'd0, wb_we}, 32'd1);
        check("lsu7_hazard_during_wb", {31'd0, hazard}, 32'd1);
        check("lsu7_busy_during_wb", busy, 32'h0000_0080);
        step();
        mid();
        check("lsu7_busy_after", busy, 32'd0);
        check("lsu7_hazard_after", {31'd0, hazard}, 32'd0);

        // Set and clear of the same register on one edge
        step();
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_9999;
        mid();
        check("issue9_busy", busy, 32'h0000_0200);
        check("alu9_ready", {31'd0, alu_ready}, 32'd1);
        push(5'd9, 32'h9999_9999);
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        mid();
        check("alu9_wb_we", {31'd0, wb_we}, 32'd1);
        step();
        issue_valid = 1'b0;
        chk_rs1 = 5'd9;
        mid();
        check("collide9_busy", busy, 32'h0000_0200);
        check("collide9_hazard", {31'd0, hazard}, 32'd1);

        // Writes and issues to x0
        step();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        mid();
        check("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        mid();
        check("x0_wb_we", {31'd0, wb_we}, 32'd0);
        step();
        issue_valid = 1'b0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        mid();
        check("x0_busy", busy, 32'h0000_0200);
        check("x0_hazard", {31'd0, hazard}, 32'd0);

        // Reset with busy bits set and requests pending
        for (int r = 1; r < 16; r++) begin
            step();
            issue_valid = 1'b1; issue_rd = 5'(r);
        end
        step();
        issue_valid = 1'b0;
        mid();
        check("fill_busy", busy, 32'h0000_FFFE);
        step();
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_3333;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h0000_4444;
        mid();
        check("inrst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("inrst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        step();
        rst = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        mid();
        check("postrst_busy", busy, 32'd0);
        check("postrst_wb_we", {31'd0, wb_we}, 32'd0);
        check("postrst_wb_reg", {27'd0, wb_reg}, 32'd0);
        check("postrst_wb_data", wb_data, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            mid();
            check("postrst_idle_wb_we", {31'd0, wb_we}, 32'd0);
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
